// File: rtl/mult_div.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// 33 cycles Start-to-result; Start ignored while Busy; HI/LO writes only while idle.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  Op,
  input  logic        Start,
  input  logic        HI_Write,
  input  logic        LO_Write,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [31:0] a_lat, b_lat;
  logic [1:0]  op_lat;

  logic        is_div, is_sgn;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] div_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] res_hi, res_lo;

  assign is_div = op_lat[1];
  assign is_sgn = ~op_lat[0];
  assign Busy   = (state != IDLE);

  // Magnitudes of the live inputs; 0x80000000 negates to itself, i.e. unsigned 2^31
  assign mag_a = (~Op[0] && A[31]) ? -A : A;
  assign mag_b = (~Op[0] && B[31]) ? -B : B;

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_nxt = {mul_sum, acc[31:1]};

  // Restoring step: acc = {remainder, dividend bits / quotient bits}
  assign div_sh   = {acc[63:32], acc[31]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opnd};
  assign div_ge   = ~div_diff[33];
  assign div_nxt  = {(div_ge ? div_diff[31:0] : div_sh[31:0]), acc[30:0], div_ge};

  always_comb begin
    prod_fix = (is_sgn && (a_lat[31] ^ b_lat[31])) ? -acc : acc;
    quo_fix  = (is_sgn && (a_lat[31] ^ b_lat[31])) ? -acc[31:0] : acc[31:0];
    rem_fix  = (is_sgn && a_lat[31]) ? -acc[63:32] : acc[63:32];
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div) begin
      if (b_lat == 32'd0) begin
        res_hi = a_lat;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      a_lat  <= 32'd0;
      b_lat  <= 32'd0;
      op_lat <= 2'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HI_Write) HI <= WData;
          if (LO_Write) LO <= WData;
          if (Start) begin
            a_lat  <= A;
            b_lat  <= B;
            op_lat <= Op;
            cnt    <= 5'd0;
            if (Op[1]) begin
              acc  <= {32'd0, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {32'd0, mag_b};
              opnd <= mag_a;
            end
          end
        end
        CALC: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          HI   <= res_hi;
          LO   <= res_lo;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
